// File: rtl/cpu_pkg.sv
// Shared constants, types and state encodings for the 14-bit accumulator CPU and
// its instruction-memory loader.
package cpu_pkg;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 14;
  localparam int unsigned DEPTH = 2048;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] instr_t;
  typedef logic [AW:0]   count_t;

  typedef enum logic [1:0] {
    LdrIdle,
    LdrLoad,
    LdrCheck,
    LdrDone
  } ldr_state_e;

  typedef enum logic [1:0] {
    FetchT0,
    FetchT1,
    FetchT2,
    FetchT3
  } fetch_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction stream channel into the loader: valid/ready handshake with a last-word flag.
interface prog_loader_if;
  import cpu_pkg::*;

  logic   in_valid;
  instr_t in_data;
  logic   in_last;
  logic   in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/prog_loader_imem.sv
// Instruction RAM: DEPTH x DW, one synchronous write port, one asynchronous read port.
module imem
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  addr_t  waddr,
  input  instr_t wdata,
  input  addr_t  raddr,
  output instr_t rdata
);

  instr_t mem [DEPTH];

  // Contents are deliberately not reset; a reload overwrites what it needs.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Streams instruction words into the instruction RAM from address 0 and holds the CPU in
// reset until a clean load completes. Define LOADER_CHECKSUM_EN to require a trailing sum word.
module prog_loader
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  prog_loader_if.slave stream,
  input  addr_t        rd_addr,
  output instr_t       rd_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output count_t       count,
  output logic         cpu_hold
);

  ldr_state_e state_q, state_d;
  addr_t      wr_addr_q, wr_addr_d;
  count_t     count_q, count_d;
  logic       error_q, error_d;
  logic       ready;
  logic       we;
`ifdef LOADER_CHECKSUM_EN
  instr_t     sum_q, sum_d;
`endif

  assign ready = (state_q == LdrLoad) || (state_q == LdrCheck);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    error_d   = error_q;
    we        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      LdrIdle, LdrDone: begin
        if (start) begin
          state_d   = LdrLoad;
          wr_addr_d = '0;
          count_d   = '0;
          error_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      LdrLoad: begin
        if (stream.in_valid) begin
          we        = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          count_d   = count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = sum_q + stream.in_data;
`endif
          if (stream.in_last) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = LdrCheck;
`else
            state_d = LdrDone;
`endif
          end else if (wr_addr_q == addr_t'(DEPTH - 1)) begin
            // Memory full without a last word: stop rather than wrap onto address 0.
            error_d = 1'b1;
            state_d = LdrDone;
          end
        end
      end
      LdrCheck: begin
`ifdef LOADER_CHECKSUM_EN
        if (stream.in_valid) begin
          error_d = (stream.in_data != sum_q);
          state_d = LdrDone;
        end
`else
        state_d = LdrIdle;
`endif
      end
      default: state_d = LdrIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LdrIdle;
      wr_addr_q <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      count_q   <= count_d;
      error_q   <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  imem u_imem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr_q),
    .wdata (stream.in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign stream.in_ready = ready;
  assign busy            = ready;
  assign done            = (state_q == LdrDone);
  assign error           = error_q;
  assign count           = count_q;
  assign cpu_hold        = !((state_q == LdrDone) && !error_q);

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-memory writer for the 14-bit accumulator CPU: accepts a stream of 14-bit instruction words over a valid/ready handshake and writes them sequentially from address 0 into a 2048 x 14 instruction RAM. The fetch side reads the same RAM through an asynchronous read port, the drop-in replacement for the fixed ROM. `cpu_hold` keeps the CPU in reset until a load completes cleanly.

## Interface
- `AW`, 11, address width (fetch MAR width)
- `DW`, 14, instruction width (IR width)
- `DEPTH`, 2048, words; must equal 2**AW

- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a load at address 0; sampled in IDLE and DONE only.
- `in_valid` in 1: word available on `in_data`.
- `in_data` in DW: instruction word.
- `in_last` in 1: qualifies final data word of the program.
- `in_ready` out 1: loader accepts a word this cycle.
- `rd_addr` in AW: fetch-side read address (from MAR).
- `rd_data` out DW: `mem[rd_addr]`, combinational.
- `busy` out 1: load in progress.
- `done` out 1: load finished; sticky until `start` or `reset`.
- `error` out 1: load failed (overflow, or checksum when enabled).
- `count` out AW+1: data words written in the current/last load.
- `cpu_hold` out 1: hold the CPU in reset.

## Operation
- States: IDLE, LOAD, CHECK (only with `LOADER_CHECKSUM_EN`), DONE.
- IDLE: `in_ready`=0, `cpu_hold`=1. `start` -> LOAD, `wr_addr`<=0, `count`<=0, `error`<=0, `done`<=0.
- LOAD: `in_ready`=1, `busy`=1. A transfer is `in_valid && in_ready`. On transfer: `mem[wr_addr]`<=`in_data`, `wr_addr`++, `count`++.
  - Transfer with `in_last`=1 -> CHECK if enabled, else DONE.
  - Transfer at `wr_addr`=DEPTH-1 with `in_last`=0: word is written, `count`=DEPTH, `error`<=1, -> DONE. No wrap to address 0.
  - `in_last` at `wr_addr`=DEPTH-1 is a legal full load with no error.
- DONE: `in_ready`=0, `done`=1, `cpu_hold`=`error`. `start` -> LOAD, clearing `done`, `error`, and `count`.
- `start` during LOAD/CHECK is ignored.
- `in_valid` outside LOAD is ignored and never written.
- `rd_data` is always `mem[rd_addr]`, including during a load. A read of the address being written returns the old word until the write edge.
- Memory contents are not initialised or cleared by `reset`.

## Timing
- Reset values: state IDLE, `in_ready`=0, `busy`=0, `done`=0, `error`=0, `count`=0, `cpu_hold`=1, `wr_addr`=0.
- `start` high at edge N: `in_ready`=1 from N+1.
- Each transfer takes 1 cycle; back-to-back transfers run at one word per cycle.
- Write data is visible on `rd_data` the cycle after the transfer edge.
- Last-word transfer at edge M:
  - without the checksum: `done`=1 and `cpu_hold`=0 from M+1, so the CPU fetch FSM starts at T0 the following edge;
  - with the checksum: see Configuration (`done` from M+2 or later).
- `reset` mid-load: IDLE on the next edge. Words already written remain in memory; `count` returns to 0.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A 14-bit running sum (mod 2**14) of accepted data words is kept.
  - After `in_last`, go to CHECK with `in_ready`=1. The next transfer is a checksum word and is not written to memory.
  - Mismatch sets `error`=1. Either way -> DONE.
  - Overflow takes precedence and skips CHECK.
- Not defined: no sum register, no CHECK state; `error` reports overflow only.

## Structure
- Shared package `cpu_pkg`:
  - `AW`/`DW`/`DEPTH` constants.
  - `addr_t`, `instr_t` typedefs.
  - loader state enum `ldr_state_e`.
  - Fetch states T0-T3 move here as well.
- Sub-module `imem`: DEPTH x DW array, one synchronous write port (`we`, `waddr`, `wdata`), one asynchronous read port.
- The loader FSM, counters, and checksum live in `prog_loader`.

## Test plan
- Reset, then `start`, stream 3 words 14'h0A01, 14'h1B02, 14'h3FFF with `in_last` on the third:
  - `done`=1 and `count`=3, `error`=0, `cpu_hold`=0;
  - `rd_addr` 0..2 returns those words.
- Same stream with `in_valid` dropped for 2 cycles between words: identical memory result, no extra writes.
- Stream 2048 words without `in_last`: `error`=1, `count`=2048, `cpu_hold`=1, address 0 unchanged; `start` then 1 word with `in_last` clears `error`.
- Assert `reset` after 5 of 10 words:
  - all outputs at reset values next cycle;
  - `rd_addr` 0..4 still return the written words.
- `start` pulse mid-load and `in_valid` while in DONE: no restart, `count` unchanged, memory unchanged.
- `LOADER_CHECKSUM_EN`: words 14'h0001, 14'h0002 + checksum 14'h0003 gives `error`=0; checksum 14'h0004 gives `error`=1, `cpu_hold`=1; address 2 not written.
